// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and constants for the mux8 round-robin arbiter.
// MUX_ARB_TIMEOUT_EN (optional) enables the hold-limit counter in the top level.
package mux_arb_pkg;

    localparam int N_REQ        = 8;
    localparam int SEL_W        = 3;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first eligible request at or after i_ptr, wrapping.
// Shared by the idle pick and the back-to-back handoff.
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N     = N_REQ,
    parameter int SEL_W = mux_arb_pkg::SEL_W
) (
    input  logic [N-1:0]     i_req,
    input  logic [SEL_W-1:0] i_ptr,
    input  logic [N-1:0]     i_mask,
    output logic             o_found,
    output logic [SEL_W-1:0] o_idx
);

    always_comb begin
        logic [SEL_W-1:0] k;
        o_found = 1'b0;
        o_idx   = '0;
        k       = '0;
        // N is a power of two, so the SEL_W-bit add wraps modulo N for free.
        for (int i = 0; i < N; i++) begin
            k = i_ptr + SEL_W'(i);
            if (!o_found && i_req[k] && i_mask[k]) begin
                o_found = 1'b1;
                o_idx   = k;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the mux8 select lines from a registered owner index.
// Define MUX_ARB_TIMEOUT_EN to revoke grants held for MAX_HOLD cycles when others wait.
module mux8_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N        = N_REQ,
    parameter int SEL_W    = mux_arb_pkg::SEL_W,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             timeout
);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_sel;
    logic [N-1:0]     r_gnt;
    logic             r_busy;
    logic             r_tmo;

    logic [N-1:0]     w_mask;
    logic             w_found;
    logic [SEL_W-1:0] w_idx;
    logic             w_load;
    logic             w_tmo_nxt;
    logic             w_hold_hit;

    // The current owner is never a handoff candidate; in IDLE everyone is.
    assign w_mask = (r_state == GRANT) ? ~(N'(1) << r_sel) : '1;

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .i_mask  (w_mask),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

`ifdef MUX_ARB_TIMEOUT_EN
    // r_hold counts completed grant cycles minus one, so the hit fires on the MAX_HOLD-th edge.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] r_hold;

    assign w_hold_hit = (r_hold >= HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst || w_load) begin
            r_hold <= '0;
        end else if (r_state == GRANT && r_hold != 8'hFF) begin
            r_hold <= r_hold + 8'd1;
        end
    end
`else
    logic w_unused_hold;
    assign w_unused_hold = ^8'(MAX_HOLD);
    assign w_hold_hit    = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_tmo_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = GRANT;
                    w_load      = 1'b1;
                end
            end
            GRANT: begin
                if (!req[r_sel]) begin
                    if (w_found) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_hold_hit && w_found) begin
                    w_load    = 1'b1;
                    w_tmo_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tmo   <= w_tmo_nxt;
            if (w_load) begin
                r_gnt  <= N'(1) << w_idx;
                r_sel  <= w_idx;
                r_ptr  <= w_idx + 1'b1;
                r_busy <= 1'b1;
            end else if (w_state_nxt == IDLE) begin
                // sel deliberately keeps the last owner so the mux path stays put.
                r_gnt  <= '0;
                r_busy <= 1'b0;
            end
        end
    end

    assign gnt     = r_gnt;
    assign sel     = r_sel;
    assign busy    = r_busy;
    assign timeout = r_tmo;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed scenarios plus randomized traffic
// compared against an owner/pointer reference model.
module tb_mux8_rr_arbiter;

    localparam int HOLD = 4;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    // Reference model: owner index (-1 = nobody), priority pointer, cycles held.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_sel   = 0;
    int m_held  = 0;
    bit m_tmo   = 1'b0;

    always #5 clk = ~clk;

    mux8_rr_arbiter #(
        .N        (8),
        .SEL_W    (3),
        .MAX_HOLD (HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    task automatic model_edge(input logic [7:0] r, input logic rs);
        int win;
        m_tmo = 1'b0;
        if (rs) begin
            m_owner = -1; m_ptr = 0; m_sel = 0; m_held = 0;
            return;
        end
        win = -1;
        for (int i = 0; i < 8; i++) begin
            int c;
            c = (m_ptr + i) % 8;
            if (win < 0 && r[c] && c != m_owner) win = c;
        end
        if (m_owner < 0 || !r[m_owner]) begin
            if (win >= 0) begin
                m_owner = win; m_sel = win; m_ptr = (win + 1) % 8; m_held = 1;
            end else begin
                m_owner = -1;
            end
        end else if (TMO_EN && m_held >= HOLD && win >= 0) begin
            m_owner = win; m_sel = win; m_ptr = (win + 1) % 8; m_held = 1;
            m_tmo = 1'b1;
        end else if (m_held < 1000) begin
            m_held++;
        end
    endtask

    function automatic logic [12:0] m_exp();
        logic [7:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return {g, 3'(m_sel), (m_owner >= 0), m_tmo};
    endfunction

    task automatic cyc(input logic [7:0] r, input logic rs);
        req = r;
        rst = rs;
        @(posedge clk);
        model_edge(r, rs);
        #1;
    endtask

    task automatic test_reset();
        cyc(8'hFF, 1'b1);
        cyc(8'hFF, 1'b1);
        total++;
        if ({gnt, sel, busy, timeout} !== 13'h0) begin
            bad++; $display("FAIL reset_state got=%h want=%h", {gnt, sel, busy, timeout}, 13'h0);
        end
        cyc(8'hFF, 1'b0);
        total++;
        if (gnt !== 8'h01 || sel !== 3'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL first_grant gnt=%h sel=%0d busy=%b want gnt=01 sel=0 busy=1", gnt, sel, busy);
        end
        cyc(8'hFE, 1'b0);
        total++;
        if (gnt !== 8'h02 || sel !== 3'd1) begin
            bad++; $display("FAIL ptr_after_reset gnt=%h sel=%0d want gnt=02 sel=1", gnt, sel);
        end
    endtask

    task automatic test_handoff();
        cyc(8'h81, 1'b1);
        cyc(8'h81, 1'b0);
        total++;
        if (gnt !== 8'h01 || sel !== 3'd0) begin
            bad++; $display("FAIL handoff_first gnt=%h sel=%0d want gnt=01 sel=0", gnt, sel);
        end
        cyc(8'h80, 1'b0);
        total++;
        if (gnt !== 8'h80 || sel !== 3'd7 || busy !== 1'b1) begin
            bad++; $display("FAIL back_to_back gnt=%h sel=%0d busy=%b want gnt=80 sel=7 busy=1", gnt, sel, busy);
        end
    endtask

    task automatic test_wrap();
        cyc(8'h00, 1'b1);
        cyc(8'h40, 1'b0);
        total++;
        if (gnt !== 8'h40 || sel !== 3'd6) begin
            bad++; $display("FAIL wrap_setup gnt=%h sel=%0d want gnt=40 sel=6", gnt, sel);
        end
        cyc(8'h06, 1'b0);
        total++;
        if (gnt !== 8'h02 || sel !== 3'd1) begin
            bad++; $display("FAIL wrap_around gnt=%h sel=%0d want gnt=02 sel=1", gnt, sel);
        end
    endtask

    task automatic test_idle();
        cyc(8'h00, 1'b1);
        cyc(8'h08, 1'b0);
        cyc(8'h00, 1'b0);
        total++;
        if (gnt !== 8'h00 || busy !== 1'b0 || sel !== 3'd3) begin
            bad++; $display("FAIL release_idle gnt=%h busy=%b sel=%0d want gnt=00 busy=0 sel=3", gnt, busy, sel);
        end
        cyc(8'h00, 1'b0);
        total++;
        if (sel !== 3'd3 || busy !== 1'b0) begin
            bad++; $display("FAIL idle_sel_stable sel=%0d busy=%b want sel=3 busy=0", sel, busy);
        end
        cyc(8'h08, 1'b0);
        total++;
        if (gnt !== 8'h08 || sel !== 3'd3 || busy !== 1'b1) begin
            bad++; $display("FAIL regrant gnt=%h sel=%0d busy=%b want gnt=08 sel=3 busy=1", gnt, sel, busy);
        end
    endtask

    task automatic test_timeout();
        int pulses;
        cyc(8'h00, 1'b1);
        pulses = 0;
        for (int i = 0; i < 21; i++) begin
            cyc(8'h03, 1'b0);
            pulses += int'(timeout);
            total++;
            if ({gnt, sel, busy, timeout} !== m_exp()) begin
                bad++; $display("FAIL hold_limit cyc=%0d got=%h want=%h", i, {gnt, sel, busy, timeout}, m_exp());
            end
        end
        total++;
        if (pulses != (TMO_EN ? 5 : 0) || gnt !== (TMO_EN ? 8'h02 : 8'h01)) begin
            bad++; $display("FAIL timeout_count pulses=%0d gnt=%h want pulses=%0d gnt=%h",
                            pulses, gnt, TMO_EN ? 5 : 0, TMO_EN ? 8'h02 : 8'h01);
        end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(8'h01, 1'b0);
            pulses += int'(timeout);
        end
        total++;
        if (pulses != 0 || gnt !== 8'h01) begin
            bad++; $display("FAIL sole_holder pulses=%0d gnt=%h want pulses=0 gnt=01", pulses, gnt);
        end
    endtask

    task automatic test_reset_mid();
        cyc(8'h00, 1'b1);
        cyc(8'h30, 1'b0);
        total++;
        if (gnt !== 8'h10 || sel !== 3'd4) begin
            bad++; $display("FAIL mid_setup gnt=%h sel=%0d want gnt=10 sel=4", gnt, sel);
        end
        cyc(8'h30, 1'b1);
        total++;
        if ({gnt, sel, busy, timeout} !== 13'h0) begin
            bad++; $display("FAIL reset_mid got=%h want=%h", {gnt, sel, busy, timeout}, 13'h0);
        end
        cyc(8'hFF, 1'b0);
        total++;
        if (gnt !== 8'h01 || sel !== 3'd0) begin
            bad++; $display("FAIL restart_ptr0 gnt=%h sel=%0d want gnt=01 sel=0", gnt, sel);
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        logic       rs;
        cyc(8'h00, 1'b1);
        r = 8'h00;
        for (int i = 0; i < 600; i++) begin
            r  = r ^ (8'($urandom) & 8'($urandom));
            rs = ($urandom_range(0, 79) == 0);
            cyc(r, rs);
            total++;
            if ({gnt, sel, busy, timeout} !== m_exp()) begin
                bad++; $display("FAIL random cyc=%0d req=%h got=%h want=%h", i, r, {gnt, sel, busy, timeout}, m_exp());
            end
        end
    endtask

    initial begin
        test_reset();
        test_handoff();
        test_wrap();
        test_idle();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
